// File: rtl/bs_pkg.sv
// Shared types and constants for the bs_pack bit-stream packer.
// Holds the FSM state type, default widths and the byte-count width helper.
package bs_pkg;

  typedef enum logic {
    ACC   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int DEF_DATA_WD = 32;
  localparam int DEF_IN_WD   = 32;

  // Width of a byte count that spans 0..data_wd/8 inclusive.
  function automatic int nbyte_w(input int data_wd);
    return $clog2(data_wd / 8) + 1;
  endfunction

endpackage

// File: rtl/bs_byte_rev.sv
// Combinational byte reverser: byte 0 of the input lands in the top byte.
// Zero latency, no flow control.
module bs_byte_rev
  import bs_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD
) (
  input  logic [DATA_WD-1:0] data,
  output logic [DATA_WD-1:0] swapped
);

  localparam int NB = DATA_WD / 8;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign swapped[8*i +: 8] = data[8*(NB-1-i) +: 8];
  end

endmodule

// File: rtl/bs_pack.sv
// MSB-first bit packer: variable-length fields in, DATA_WD words out; 1 cycle from completing beat to val_o.
// Input stalls (rdy_o low) while a full word waits behind a blocked output register or during flush.
module bs_pack
  import bs_pkg::*;
#(
  parameter int DATA_WD  = DEF_DATA_WD,
  parameter int IN_WD    = DEF_IN_WD,
  parameter bit BYTE_REV = 1'b0,
  localparam int NB_W    = (IN_WD > 1) ? $clog2(IN_WD) : 1,
  localparam int NBYTE_W = nbyte_w(DATA_WD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [IN_WD-1:0]   dat_i,
  input  logic [NB_W-1:0]    numb_i,
  input  logic               flush_i,
  output logic               val_o,
  input  logic               rdy_i,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NBYTE_W-1:0] nbyte_o,
  output logic               last_o
);

  localparam int ACC_W = DATA_WD + IN_WD - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] DATA_C = CNT_W'(DATA_WD);
  localparam logic [CNT_W-1:0] ACC_C  = CNT_W'(ACC_W);

  state_t               state, state_n;
  logic [ACC_W-1:0]     acc, acc_n, acc_a, fld;
  logic [CNT_W-1:0]     cnt, cnt_n, cnt_a, len;
  logic                 take, fl_take, out_free, load, load_last;
  logic [DATA_WD-1:0]   word, dat_q;
  logic [NBYTE_W-1:0]   nbyte_n;

  assign rdy_o    = (state == ACC) && (cnt < DATA_C);
  assign take     = val_i && rdy_o;
  assign fl_take  = flush_i && rdy_o;
  assign out_free = !val_o || rdy_i;
  assign len      = CNT_W'(numb_i) + CNT_W'(1);

  // Valid bits sit left-aligned in acc; everything below the fill count is zero.
  always_comb begin
    fld   = ACC_W'(dat_i) & ~({ACC_W{1'b1}} << len);
    acc_a = acc;
    cnt_a = cnt;
    if (take) begin
      acc_a = acc | (fld << (ACC_C - cnt - len));
      cnt_a = cnt + len;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc_a;
    cnt_n     = cnt_a;
    load      = 1'b0;
    load_last = 1'b0;
    nbyte_n   = NBYTE_W'(DATA_WD / 8);
    word      = acc_a[ACC_W-1 -: DATA_WD];
    case (state)
      ACC: begin
        if (out_free && (cnt_a >= DATA_C)) begin
          load      = 1'b1;
          acc_n     = acc_a << DATA_WD;
          cnt_n     = cnt_a - DATA_C;
          load_last = fl_take && (cnt_a == DATA_C);
        end
        // A flush that empties exactly on this word ends the stream right here.
        if (fl_take && !load_last) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          load_last = (cnt <= DATA_C);
          if (cnt >= DATA_C) begin
            acc_n = acc << DATA_WD;
            cnt_n = cnt - DATA_C;
          end else begin
            acc_n   = '0;
            cnt_n   = '0;
            nbyte_n = NBYTE_W'((cnt + CNT_W'(7)) >> 3);
          end
          if (load_last) begin
            state_n = ACC;
          end
        end
      end
      default: state_n = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      val_o   <= 1'b0;
      last_o  <= 1'b0;
      nbyte_o <= '0;
      dat_q   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      if (load) begin
        val_o   <= 1'b1;
        dat_q   <= word;
        nbyte_o <= nbyte_n;
        last_o  <= load_last;
      end else if (rdy_i) begin
        val_o <= 1'b0;
      end
    end
  end

  if (BYTE_REV) begin : g_rev
    bs_byte_rev #(.DATA_WD(DATA_WD)) u_rev (
      .data    (dat_q),
      .swapped (dat_o)
    );
  end else begin : g_norev
    assign dat_o = dat_q;
  end

endmodule

// File: tb/tb_bs_pack.sv
// Bench for bs_pack: two instances (plain and byte-reversed) share stimulus;
// a bit-queue model predicts every output word.
module tb_bs_pack;
  import bs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_i = 1'b0, flush_i = 1'b0, rdy_i = 1'b1;
  logic [31:0] dat_i = '0;
  logic [4:0]  numb_i = '0;
  logic        rdy_o, val_o, last_o, rdy_o1, val_o1, last_o1;
  logic [31:0] dat_o, dat_o1;
  logic [2:0]  nbyte_o, nbyte_o1;

  always #5 clk = ~clk;

  bs_pack #(.DATA_WD(32), .IN_WD(32), .BYTE_REV(1'b0)) dut (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o), .dat_i(dat_i), .numb_i(numb_i),
    .flush_i(flush_i), .val_o(val_o), .rdy_i(rdy_i), .dat_o(dat_o), .nbyte_o(nbyte_o), .last_o(last_o));

  bs_pack #(.DATA_WD(32), .IN_WD(32), .BYTE_REV(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o1), .dat_i(dat_i), .numb_i(numb_i),
    .flush_i(flush_i), .val_o(val_o1), .rdy_i(rdy_i), .dat_o(dat_o1), .nbyte_o(nbyte_o1), .last_o(last_o1));

  typedef struct {
    logic [31:0] dat;
    logic [31:0] rdat;
    int          nbyte;
    logic        last;
  } wrd_t;

  bit   bits[$];
  wrd_t exp_q[$];
  wrd_t obs_q[$];
  int   total = 0, bad = 0, stab_err = 0, pair_err = 0;
  int   bp_mode = 0;  // 0: always ready, 1: random, 2: never ready
  logic held = 1'b0;
  logic [31:0] hd;
  logic [2:0]  hn;
  logic        hl;

  function automatic logic [31:0] brev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic wrd_t mk(input logic [31:0] w, input int nb, input logic l);
    wrd_t r;
    r.dat = w; r.rdat = brev(w); r.nbyte = nb; r.last = l;
    return r;
  endfunction

  // Reference: a flat bit stream cut into 32-bit words, MSB first.
  task automatic model_accept(input logic v, input logic [31:0] d, input int n, input logic f);
    logic [31:0] w;
    int r;
    bit got = 0;
    if (v) for (int b = n; b >= 0; b--) bits.push_back(d[b]);
    while (bits.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], bits.pop_front()};
      exp_q.push_back(mk(w, 4, f && (bits.size() == 0)));
      got = 1;
    end
    if (f && bits.size() > 0) begin
      r = bits.size();
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], (i < r) ? bits.pop_front() : 1'b0};
      exp_q.push_back(mk(w, (r + 7) / 8, 1'b1));
    end else if (f && !got) begin
      exp_q.push_back(mk(32'h0, 0, 1'b1));
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0: rdy_i = 1'b1;
      1: rdy_i = 1'($urandom % 2);
      default: rdy_i = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && (!val_o || dat_o !== hd || nbyte_o !== hn || last_o !== hl)) stab_err++;
      if (rdy_o1 !== rdy_o || val_o1 !== val_o || nbyte_o1 !== nbyte_o || last_o1 !== last_o) pair_err++;
      if (val_o && rdy_i) obs_q.push_back('{dat_o, dat_o1, int'(nbyte_o), last_o});
      held = val_o && !rdy_i;
      hd = dat_o; hn = nbyte_o; hl = last_o;
    end
  end

  task automatic do_reset();
    bp_mode = 0;
    val_i = 1'b0; flush_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bits.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input int n, input logic f);
    int to = 0;
    val_i = v; dat_i = d; numb_i = n[4:0]; flush_i = f;
    @(negedge clk);
    while (!rdy_o && to < 200) begin to++; @(negedge clk); end
    if (!rdy_o) begin
      total++; bad++;
      $display("FAIL accept_timeout: rdy_o=%0b after %0d cycles, want 1", rdy_o, to);
    end else begin
      model_accept(v, d, n, f);
    end
    @(posedge clk);
    #1 val_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic wait_drain(output bit to);
    int c = 0;
    while (obs_q.size() < exp_q.size() && c < 1000) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    to = (obs_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (val_o !== 1'b0)   begin bad++; $display("FAIL rst_val: got %0b want 0", val_o); end
    total++; if (last_o !== 1'b0)  begin bad++; $display("FAIL rst_last: got %0b want 0", last_o); end
    total++; if (nbyte_o !== 3'd0) begin bad++; $display("FAIL rst_nbyte: got %0d want 0", nbyte_o); end
    total++; if (dat_o !== 32'h0)  begin bad++; $display("FAIL rst_dat: got %h want 0", dat_o); end
    total++; if (rdy_o !== 1'b1)   begin bad++; $display("FAIL rst_rdy: got %0b want 1", rdy_o); end
  endtask

  task automatic test_nibbles();
    wrd_t e, o;
    bit to;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin
        total++; if (val_o !== 1'b0) begin bad++; $display("FAIL nib_early: val_o=%0b want 0", val_o); end
      end
      drive(1'b1, 32'(k), 3, 1'b0);
    end
    total++; if (val_o !== 1'b1) begin bad++; $display("FAIL nib_latency: val_o=%0b want 1", val_o); end
    total++; if (dat_o !== 32'h12345678) begin bad++; $display("FAIL nib_dat: got %h want 12345678", dat_o); end
    total++; if (dat_o1 !== 32'h78563412) begin bad++; $display("FAIL nib_rev: got %h want 78563412", dat_o1); end
    total++; if (nbyte_o !== 3'd4 || last_o !== 1'b0) begin bad++; $display("FAIL nib_meta: nbyte %0d last %0b want 4 0", nbyte_o, last_o); end
    wait_drain(to);
    total++; if (to || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL nib_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.dat !== e.dat || o.rdat !== e.rdat || o.nbyte !== e.nbyte || o.last !== e.last) begin
        bad++; $display("FAIL nib_word: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", o.dat, o.rdat, o.nbyte, o.last, e.dat, e.rdat, e.nbyte, e.last);
      end
    end
  endtask

  task automatic test_flush_residue();
    wrd_t e, o;
    bit to;
    do_reset();
    drive(1'b1, 32'hFFFABCDE, 19, 1'b0);  // upper bits must be masked
    drive(1'b1, 32'h00012345, 19, 1'b0);
    drive(1'b0, 32'h0, 0, 1'b1);
    wait_drain(to);
    total++; if (to || obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL res_count: got %0d words want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0].dat !== 32'hABCDE123 || obs_q[0].nbyte != 4 || obs_q[0].last !== 1'b0) begin
        bad++; $display("FAIL res_w0: got %h/%0d/%0b want abcde123/4/0", obs_q[0].dat, obs_q[0].nbyte, obs_q[0].last); end
      total++; if (obs_q[1].dat !== 32'h45000000 || obs_q[1].nbyte != 1 || obs_q[1].last !== 1'b1) begin
        bad++; $display("FAIL res_w1: got %h/%0d/%0b want 45000000/1/1", obs_q[1].dat, obs_q[1].nbyte, obs_q[1].last); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.dat !== e.dat || o.rdat !== e.rdat || o.nbyte !== e.nbyte || o.last !== e.last) begin
        bad++; $display("FAIL res_word: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", o.dat, o.rdat, o.nbyte, o.last, e.dat, e.rdat, e.nbyte, e.last);
      end
    end
  endtask

  task automatic test_flush_edges();
    bit to;
    do_reset();
    drive(1'b0, 32'h0, 0, 1'b1);
    drive(1'b1, 32'hC0FFEE11, 31, 1'b1);
    wait_drain(to);
    total++; if (to || obs_q.size() != 2 || exp_q.size() != 2) begin bad++; $display("FAIL edge_count: got %0d words want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0].dat !== 32'h0 || obs_q[0].nbyte != 0 || obs_q[0].last !== 1'b1) begin
        bad++; $display("FAIL edge_empty: got %h/%0d/%0b want 0/0/1", obs_q[0].dat, obs_q[0].nbyte, obs_q[0].last); end
      total++; if (obs_q[1].dat !== 32'hC0FFEE11 || obs_q[1].nbyte != 4 || obs_q[1].last !== 1'b1) begin
        bad++; $display("FAIL edge_single: got %h/%0d/%0b want c0ffee11/4/1", obs_q[1].dat, obs_q[1].nbyte, obs_q[1].last); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    wrd_t e, o;
    bit to;
    logic [31:0] snap;
    do_reset();
    bp_mode = 2;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) drive(1'b1, $urandom, 15, 1'b0);
    total++; if (rdy_o !== 1'b0 || val_o !== 1'b1) begin bad++; $display("FAIL bp_stall: rdy_o=%0b val_o=%0b want 0 1", rdy_o, val_o); end
    snap = dat_o;
    repeat (5) @(posedge clk);
    #1;
    total++; if (dat_o !== snap || rdy_o !== 1'b0) begin bad++; $display("FAIL bp_hold: dat %h rdy %0b want %h 0", dat_o, rdy_o, snap); end
    bp_mode = 0;
    drive(1'b1, $urandom, 15, 1'b0);
    drive(1'b0, 32'h0, 0, 1'b1);
    wait_drain(to);
    total++; if (to || obs_q.size() != 3 || exp_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d words want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.dat !== e.dat || o.rdat !== e.rdat || o.nbyte !== e.nbyte || o.last !== e.last) begin
        bad++; $display("FAIL bp_word: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", o.dat, o.rdat, o.nbyte, o.last, e.dat, e.rdat, e.nbyte, e.last);
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable: %0d unstable cycles want 0", stab_err); end
  endtask

  task automatic test_random();
    wrd_t e, o;
    bit to;
    do_reset();
    bp_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom % 12 == 0) drive(1'b0, 32'h0, 0, 1'b1);
      else drive(1'b1, $urandom, int'($urandom % 32), 1'($urandom % 8 == 0));
    end
    drive(1'b0, 32'h0, 0, 1'b1);
    wait_drain(to);
    total++; if (to || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count: got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.dat !== e.dat || o.rdat !== e.rdat || o.nbyte !== e.nbyte || o.last !== e.last) begin
        bad++; $display("FAIL rnd_word: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", o.dat, o.rdat, o.nbyte, o.last, e.dat, e.rdat, e.nbyte, e.last);
      end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL rnd_stable: %0d unstable cycles want 0", stab_err); end
    total++; if (pair_err != 0) begin bad++; $display("FAIL rnd_pair: %0d rev-instance diffs want 0", pair_err); end
  endtask

  task automatic test_reset_in_flush();
    wrd_t e, o;
    bit to;
    do_reset();
    bp_mode = 2;
    @(posedge clk); #1;
    drive(1'b1, $urandom, 31, 1'b0);
    drive(1'b1, 32'hFFF, 11, 1'b0);
    drive(1'b0, 32'h0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (rdy_o !== 1'b0 || val_o !== 1'b1) begin bad++; $display("FAIL rf_stuck: rdy_o=%0b val_o=%0b want 0 1", rdy_o, val_o); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++; if (val_o !== 1'b0 || rdy_o !== 1'b1) begin bad++; $display("FAIL rf_after: val_o=%0b rdy_o=%0b want 0 1", val_o, rdy_o); end
    bits.delete(); exp_q.delete(); obs_q.delete();
    bp_mode = 0;
    for (int k = 1; k <= 8; k++) drive(1'b1, 32'(k), 3, k == 8);
    wait_drain(to);
    total++; if (to || obs_q.size() != 1 || exp_q.size() != 1) begin bad++; $display("FAIL rf_count: got %0d words want 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      total++; if (obs_q[0].dat !== 32'h12345678 || obs_q[0].nbyte != 4 || obs_q[0].last !== 1'b1) begin
        bad++; $display("FAIL rf_clean: got %h/%0d/%0b want 12345678/4/1", obs_q[0].dat, obs_q[0].nbyte, obs_q[0].last); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.dat !== e.dat || o.rdat !== e.rdat || o.nbyte !== e.nbyte || o.last !== e.last) begin
        bad++; $display("FAIL rf_word: got %h/%h/%0d/%0b want %h/%h/%0d/%0b", o.dat, o.rdat, o.nbyte, o.last, e.dat, e.rdat, e.nbyte, e.last);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nibbles();
    test_flush_residue();
    test_flush_edges();
    test_backpressure();
    test_random();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
